// File: rtl/load_store_unit_if.sv
// Execute-stage request/response handshake plus the word-memory port of load_store_unit.
// master = request initiator and memory model side, slave = the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_write_en, mem_read_en, mem_addr, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_write_en, mem_read_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed memory without byte enables;
// sub-word stores are done as read-modify-write.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   LOAD   | memory read, extended lane captured into the result
//   RMW_RD | memory read, target lane replaced by store data
//   WRITE  | memory write of merged word or full store word
//   RESP   | one-cycle resp_valid pulse
module load_store_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t                  state;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic [15:0]             wdata_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    resp_valid_q;
  logic                    resp_error_q;
  logic                    req_ready_q;
  logic                    rd_q;
  logic                    wr_q;

  logic                    req_err;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merge;
  logic                    unused_addr;

  assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    req_err = 1'b1;
    case (bus.req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = bus.req_addr[0];
      F3_W:    req_err = |bus.req_addr[1:0];
      F3_BU:   req_err = bus.req_write;
      F3_HU:   req_err = bus.req_write | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = bus.mem_read_data[7:0];
    case (off_q)
      2'd1:    byte_sel = bus.mem_read_data[15:8];
      2'd2:    byte_sel = bus.mem_read_data[23:16];
      2'd3:    byte_sel = bus.mem_read_data[31:24];
      default: byte_sel = bus.mem_read_data[7:0];
    endcase
    half_sel = off_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

    case (funct3_q)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_ext = {24'b0, byte_sel};
      F3_HU:   load_ext = {16'b0, half_sel};
      default: load_ext = bus.mem_read_data;
    endcase

    // Only B and H reach RMW_RD, so funct3 bit 0 picks half vs byte lane.
    merge = bus.mem_read_data;
    if (funct3_q[0]) begin
      if (off_q[1]) merge[31:16] = wdata_q;
      else          merge[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd1:    merge[15:8]  = wdata_q[7:0];
        2'd2:    merge[23:16] = wdata_q[7:0];
        2'd3:    merge[31:24] = wdata_q[7:0];
        default: merge[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      funct3_q     <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      req_ready_q  <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            funct3_q    <= bus.req_funct3;
            off_q       <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata[15:0];
            mem_addr_q  <= bus.req_addr[ADDR_WIDTH+1:2];
            req_ready_q <= 1'b0;
            if (req_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else if (!bus.req_write) begin
              state <= LOAD;
              rd_q  <= 1'b1;
            end else if (bus.req_funct3 == F3_W) begin
              state       <= WRITE;
              wr_q        <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state <= RMW_RD;
              rd_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          rd_q         <= 1'b0;
          resp_rdata_q <= load_ext;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RMW_RD: begin
          rd_q        <= 1'b0;
          wr_q        <= 1'b1;
          mem_wdata_q <= merge;
          state       <= WRITE;
        end
        WRITE: begin
          wr_q         <= 1'b0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_error_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enables are gated by reset so an aborted WRITE cycle cannot commit.
  assign bus.mem_read_en    = rd_q & rst_n;
  assign bus.mem_write_en   = wr_q & rst_n;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_error     = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table and scoreboard against a behavioural word memory,
// plus back-to-back handshake and reset-during-write sequences.
module tb_load_store_unit;
  localparam int AW = 8;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();
  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [31:0] mem [256] = '{default: '0};
  assign bus.mem_read_data = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_data;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            lat;
    int            nrd;
    int            nwr;
    logic [AW-1:0] maddr;
    int            cyc;
    int            rd0;
    int            wr0;
  } exp_t;

  vec_t tbl[$];
  vec_t b2b[$];
  exp_t sb[$];
  exp_t pend;
  int total = 0, bad = 0, cyc = 0, n_rd = 0, n_wr = 0, n_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input vec_t v);
    exp_t e;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.maddr = v.addr[AW+1:2];
    e.cyc = 0; e.rd0 = 0; e.wr0 = 0;
    if (v.err)              begin e.lat = 1; e.nrd = 0; e.nwr = 0; end
    else if (!v.wr)         begin e.lat = 2; e.nrd = 1; e.nwr = 0; end
    else if (v.f3 == F_W)   begin e.lat = 2; e.nrd = 0; e.nwr = 1; end
    else                    begin e.lat = 3; e.nrd = 1; e.nwr = 1; end
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Scoreboard monitor: acceptances push, responses pop.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_read_en)  n_rd++;
    if (bus.mem_write_en) n_wr++;
    if (rst_n) begin
      if (sb.size() > 0) check("ready_low_busy", bus.req_ready, 0);
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_error", bus.resp_error, e.err);
          check("latency", cyc - e.cyc, e.lat);
          check("read_cycles", n_rd - e.rd0, e.nrd);
          check("write_cycles", n_wr - e.wr0, e.nwr);
          check("mem_addr", bus.mem_addr, e.maddr);
        end
      end else begin
        check("rdata_idle", bus.resp_rdata, 0);
        check("error_idle", bus.resp_error, 0);
      end
      if (!bus.mem_write_en) check("wdata_idle", bus.mem_write_data, 0);
      if (bus.req_valid && bus.req_ready) begin
        n_acc++;
        e = pend;
        e.cyc = cyc; e.rd0 = n_rd; e.wr0 = n_wr;
        sb.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive(input vec_t v);
    int acc0 = n_acc;
    int guard = 0;
    pend           = make_exp(v);
    bus.req_write  = v.wr;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    while (n_acc == acc0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (n_acc == acc0) begin
      total++; bad++;
      $display("FAIL accept_timeout: addr 0x%08h not accepted in 40 cycles", v.addr);
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: %0d responses still outstanding", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_start;
    // Word round trip, byte/half loads, RMW stores, errors, more lanes.
    tbl.push_back(mk(1, F_W,  32'h10,  32'hDEADBEEF, 32'h0,        0));
    tbl.push_back(mk(0, F_W,  32'h10,  32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(1, F_W,  32'h20,  32'hCAFEF00D, 32'h0,        0));
    tbl.push_back(mk(1, F_W,  32'h10,  32'h80FF7F01, 32'h0,        0));
    tbl.push_back(mk(0, F_B,  32'h13,  32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mk(0, F_BU, 32'h13,  32'h0,        32'h00000080, 0));
    tbl.push_back(mk(0, F_B,  32'h11,  32'h0,        32'h0000007F, 0));
    tbl.push_back(mk(0, F_H,  32'h12,  32'h0,        32'hFFFF80FF, 0));
    tbl.push_back(mk(0, F_HU, 32'h12,  32'h0,        32'h000080FF, 0));
    tbl.push_back(mk(0, F_B,  32'h10,  32'h0,        32'h00000001, 0));
    tbl.push_back(mk(0, F_H,  32'h10,  32'h0,        32'h00007F01, 0));
    tbl.push_back(mk(0, F_BU, 32'h12,  32'h0,        32'h000000FF, 0));
    tbl.push_back(mk(0, F_B,  32'h12,  32'h0,        32'hFFFFFFFF, 0));
    tbl.push_back(mk(0, F_W,  32'h410, 32'h0,        32'h80FF7F01, 0));
    tbl.push_back(mk(1, F_W,  32'h10,  32'h11223344, 32'h0,        0));
    tbl.push_back(mk(1, F_B,  32'h11,  32'h123456AA, 32'h0,        0));
    tbl.push_back(mk(0, F_W,  32'h10,  32'h0,        32'h1122AA44, 0));
    tbl.push_back(mk(1, F_H,  32'h12,  32'h9999BEEF, 32'h0,        0));
    tbl.push_back(mk(0, F_W,  32'h10,  32'h0,        32'hBEEFAA44, 0));
    tbl.push_back(mk(0, F_W,  32'h12,  32'h0,        32'h0,        1));
    tbl.push_back(mk(1, F_H,  32'h13,  32'h00001234, 32'h0,        1));
    tbl.push_back(mk(0, F_H,  32'h01,  32'h0,        32'h0,        1));
    tbl.push_back(mk(0, 3'b011, 32'h10, 32'h0,       32'h0,        1));
    tbl.push_back(mk(1, F_BU, 32'h10,  32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk(1, F_HU, 32'h10,  32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk(0, 3'b110, 32'h10, 32'h0,       32'h0,        1));
    tbl.push_back(mk(0, 3'b111, 32'h10, 32'h0,       32'h0,        1));
    tbl.push_back(mk(0, F_HU, 32'h13,  32'h0,        32'h0,        1));
    tbl.push_back(mk(0, F_W,  32'h10,  32'h0,        32'hBEEFAA44, 0));
    tbl.push_back(mk(1, F_B,  32'h13,  32'h00000077, 32'h0,        0));
    tbl.push_back(mk(1, F_B,  32'h10,  32'h00000000, 32'h0,        0));
    tbl.push_back(mk(0, F_W,  32'h10,  32'h0,        32'h77EFAA00, 0));
    tbl.push_back(mk(0, F_HU, 32'h10,  32'h0,        32'h0000AA00, 0));
    tbl.push_back(mk(0, F_H,  32'h12,  32'h0,        32'h000077EF, 0));
    tbl.push_back(mk(1, F_H,  32'h10,  32'h0000FFFE, 32'h0,        0));
    tbl.push_back(mk(0, F_H,  32'h10,  32'h0,        32'hFFFFFFFE, 0));
    tbl.push_back(mk(0, F_BU, 32'h11,  32'h0,        32'h000000FF, 0));

    b2b.push_back(mk(0, F_W,  32'h10,  32'h0,        32'h77EFFFFE, 0));
    b2b.push_back(mk(1, F_B,  32'h14,  32'h0000005A, 32'h0,        0));
    b2b.push_back(mk(0, F_H,  32'h01,  32'h0,        32'h0,        1));
    b2b.push_back(mk(0, F_W,  32'h14,  32'h0,        32'h0000005A, 0));

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_error", bus.resp_error, 0);
    check("rst_mem_read_en", bus.mem_read_en, 0);
    check("rst_mem_write_en", bus.mem_write_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_write_data", bus.mem_write_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", bus.req_ready, 1);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      bus.req_valid = 1'b0;
      wait_done();
    end
    check("mem_word4", mem[4], 32'h77EFFFFE);
    check("mem_word8", mem[8], 32'hCAFEF00D);

    // req_valid held high across consecutive requests.
    acc_start = n_acc;
    foreach (b2b[i]) drive(b2b[i]);
    bus.req_valid = 1'b0;
    wait_done();
    check("b2b_acceptances", n_acc - acc_start, 4);
    check("mem_word5", mem[5], 32'h0000005A);

    // Reset asserted during the WRITE cycle of a byte store.
    drive(mk(1, F_B, 32'h20, 32'h00000055, 32'h0, 0));
    bus.req_valid = 1'b0;
    check("rmw_read_en", bus.mem_read_en, 1);
    @(posedge clk); #1;
    check("rmw_write_en", bus.mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    check("write_en_gated", bus.mem_write_en, 0);
    @(posedge clk); #1;
    sb.delete();
    check("abort_resp_valid", bus.resp_valid, 0);
    check("abort_mem_read_en", bus.mem_read_en, 0);
    check("abort_mem_write_en", bus.mem_write_en, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_mem_write_data", bus.mem_write_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", bus.req_ready, 1);
    check("abort_resp_valid2", bus.resp_valid, 0);
    check("abort_resp_rdata", bus.resp_rdata, 0);
    check("mem_word8_unchanged", mem[8], 32'hCAFEF00D);

    drive(mk(0, F_W, 32'h20, 32'h0, 32'hCAFEF00D, 0));
    bus.req_valid = 1'b0;
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
